// File: rtl/led_frame_fifo.sv
// Pixel FIFO (first-word-fall-through) with a frame sequencer for an LED serializer.
// Optional sticky overflow/underflow flags are built when LED_FIFO_STATUS_EN is defined.
module led_frame_fifo #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 16,
  parameter int LED_NUM = 4,
  parameter int GAP_CYC = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_start,
  output logic                     busy,
  input  logic                     err_clr,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              empty_q, full_q;
  logic              push, pop;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic              frame_start_q, busy_q;

  // A push into a full FIFO is still legal when a real pop frees a slot this cycle.
  assign pop  = !rst && rd_en && !empty_q;
  assign push = !rst && wr_en && (!full_q || pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + LVL_W'(1);
    else if (pop && !push)
      level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LVL_W'(DEPTH));
    end
  end

  // Only pops taken while in SEND count towards the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      gap_q         <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q >= LVL_W'(LED_NUM)) begin
            state_q       <= START;
            frame_start_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        START: begin
          state_q       <= SEND;
          frame_start_q <= 1'b0;
        end
        SEND: begin
          if (pop) begin
            if (cnt_q == CNT_W'(LED_NUM - 1)) begin
              cnt_q <= '0;
              if (GAP_CYC == 0) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= GAP;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            gap_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: begin
          state_q       <= IDLE;
          frame_start_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_FIFO_STATUS_EN
  logic overflow_q, underflow_q;

  // A new error in the same cycle as err_clr wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= (overflow_q  && !err_clr) || (wr_en && !push);
      underflow_q <= (underflow_q && !err_clr) || (rd_en && empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign rd_data     = mem_q[rd_ptr_q];
  assign empty       = empty_q;
  assign full        = full_q;
  assign level       = level_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: doc/led_frame_fifo.md
LED_FRAME_FIFO -- requirements
Module: led_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 24, pixel word width (one RGB pixel, 8 bits per channel).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter LED_NUM, default 4, pixels per frame; 1 <= LED_NUM <= DEPTH.
REQ-004 SHALL have parameter GAP_CYC, default 5, idle cycles enforced between frames.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  push request from pixel source.
REQ-008 SHALL have port wr_data  input  DATA_W  pixel to push.
REQ-009 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-010 SHALL have port rd_en  input  1  pop request from the LED serializer.
REQ-011 SHALL have port rd_data  output  DATA_W  head pixel, first-word-fall-through; feeds the serializer's fifo_data_in.
REQ-012 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse; drives the serializer's enable.
REQ-015 SHALL have port busy  output  1  high in states START, SEND and GAP.
REQ-016 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-017 SHALL have port overflow  output  1  sticky: a push was dropped.
REQ-018 SHALL have port underflow  output  1  sticky: a pop was ignored.

Function
REQ-019 SHALL accept a push when wr_en=1 and (full=0, or rd_en=1 with empty=0 in the same cycle); otherwise the push SHALL be dropped.
REQ-020 SHALL accept a pop when rd_en=1 and empty=0; a pop on empty SHALL be ignored, even if a push occurs in the same cycle.
REQ-021 SHALL present rd_data as the oldest entry whenever empty=0, with no read latency; rd_data is don't-care when empty=1.
REQ-022 SHALL make a pushed word visible on rd_data in the cycle after the push when the FIFO was empty.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; full, empty and level SHALL be registered and exact after every cycle.
REQ-024 SHALL keep level unchanged on a simultaneous accepted push and pop, increment it on a push only, and decrement it on a pop only.
REQ-025 SHALL implement FSM states IDLE, START, SEND and GAP.
REQ-026 IDLE -> START SHALL occur when level >= LED_NUM.
REQ-027 START SHALL last exactly one cycle with frame_start=1, then go to SEND.
REQ-028 SEND SHALL count accepted pops, starting from 0, and go to GAP in the cycle after the LED_NUM-th pop.
REQ-029 GAP SHALL last exactly GAP_CYC cycles, then return to IDLE; with GAP_CYC=0, SEND SHALL go directly to IDLE.
REQ-030 Pops outside SEND SHALL be accepted by the FIFO but SHALL NOT advance the frame counter.
REQ-031 Pushes SHALL be accepted in every state.
REQ-032 frame_start SHALL be 0 in every state other than START.

Reset
REQ-033 On rst=1 at a clock edge: pointers=0, level=0, empty=1, full=0, state=IDLE, frame counter=0, GAP counter=0, frame_start=0, busy=0, overflow=0, underflow=0.
REQ-034 Reset mid-frame SHALL discard all stored pixels and abort the frame with no further frame_start pulse.
REQ-035 During reset, wr_en and rd_en SHALL be ignored.

Configuration
REQ-036 Macro LED_FIFO_STATUS_EN defined: overflow SHALL set on every dropped push and underflow on every ignored pop; both SHALL hold until err_clr=1 or reset; when err_clr and a new error coincide, the flag SHALL remain set.
REQ-037 Macro LED_FIFO_STATUS_EN undefined: overflow and underflow SHALL be constant 0 and err_clr SHALL be ignored; all other behaviour is unchanged.

Verification
REQ-038 Reset release, then push 0x555555, 0xAAAAAA, 0x123456, 0xFFFFFF on consecutive cycles -> level reaches 4, frame_start pulses exactly once, on the cycle after level=4 is first observed, with busy=1.
REQ-039 In SEND, pop 4 times with gaps -> rd_data reads 0x555555, 0xAAAAAA, 0x123456, 0xFFFFFF in order; the state is GAP for exactly 5 cycles, then IDLE; empty=1.
REQ-040 Fill 16 entries, then a 17th push alone -> full=1, the word is dropped, level=16, overflow=1 (STATUS_EN); a 17th push together with a pop -> level stays 16 and both are accepted.
REQ-041 Pop on empty while pushing 0x0000FF -> the pop is ignored, level=1, rd_data=0x0000FF next cycle, underflow=1 (STATUS_EN) until err_clr.
REQ-042 Assert rst after 2 of 4 frame pops -> next cycle level=0, state IDLE, busy=0; push 3 pixels -> no frame_start.
REQ-043 Build without LED_FIFO_STATUS_EN and repeat REQ-040 and REQ-041 -> overflow=underflow=0 throughout, all data behaviour identical.
